// File: rtl/pe_edge_drain.sv
// -----------------------------------------------------------------------------
// pe_pkg / pe_edge_drain
//
// Right-edge drain of a systolic PE row. While ARMED it captures a requested
// number of computed words (every opcode except OPCD_PASS) from the last PE's
// right output. The words go into a FIFO that the host reads over a
// valid/ready port. The array never stalls, so a word that arrives at a full
// FIFO is dropped and recorded in a sticky overflow flag.
//
// Optional feature macro: PE_DRAIN_OVF_CNT_EN. When it is defined, the block
// adds the ovf_cnt port and a 16-bit saturating count of dropped words.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   left            dbus_t stream from the last PE's right output
//   start, count    arm a capture of `count` words (honoured only in IDLE)
//   busy            high in ARMED or DRAIN
//   done            one-cycle pulse after DRAIN->IDLE
//   m_valid/m_ready host handshake for the FIFO head
//   m_data, m_opcd  FIFO head word
//   fill            FIFO occupancy (0..DEPTH)
//   ovf_cnt         saturating dropped-word count (PE_DRAIN_OVF_CNT_EN only)
//   overflow        sticky: a qualifying word was dropped
// -----------------------------------------------------------------------------
package pe_pkg;
  localparam int unsigned PE_DW = 16;

  typedef enum logic [2:0] {
    OPCD_PASS = 3'd0,
    OPCD_MAC  = 3'd1,
    OPCD_ADD  = 3'd2,
    OPCD_MUL  = 3'd3,
    OPCD_LOAD = 3'd4,
    OPCD_OUT  = 3'd5
  } opcd_t;

  typedef struct packed {
    opcd_t             opcd;
    logic [PE_DW-1:0]  data;
  } dbus_t;
endpackage

module pe_edge_drain
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  dbus_t                   left,
  input  logic                    start,
  input  logic [CW-1:0]           count,
  output logic                    busy,
  output logic                    done,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PE_DW-1:0]        m_data,
  output opcd_t                   m_opcd,
  output logic [$clog2(DEPTH):0]  fill,
`ifdef PE_DRAIN_OVF_CNT_EN
  output logic [15:0]             ovf_cnt,
`endif
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  dbus_t           r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [FW-1:0]   r_fill;
  logic [CW-1:0]   r_remaining;
  logic            r_done;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_qual;
  logic            w_push;
  logic            w_drop;
  logic            w_start_acc;
  logic            w_arm;
  logic            w_drain_exit;

  assign w_empty      = (r_fill == '0);
  assign w_full       = (r_fill == FW'(DEPTH));
  assign w_pop        = !w_empty && m_ready;
  assign w_qual       = (r_state == S_ARMED) && (left.opcd != OPCD_PASS);
  // A pop in the same cycle frees a slot, so a word arriving at a full FIFO
  // is still accepted when the host is reading.
  assign w_push       = w_qual && (!w_full || w_pop);
  assign w_drop       = w_qual && w_full && !w_pop;
  assign w_start_acc  = (r_state == S_IDLE) && start;
  assign w_arm        = w_start_acc && (count != '0);
  assign w_drain_exit = (r_state == S_DRAIN) && w_empty;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (count != '0) ? S_ARMED : S_DRAIN;
        end
      end
      S_ARMED: begin
        if (w_qual && (r_remaining == CW'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_drain_exit;
      if (w_arm) begin
        r_remaining <= count;
      end else if (w_qual) begin
        r_remaining <= r_remaining - CW'(1);
      end
      if (w_arm) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef PE_DRAIN_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_start_acc) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  // ---------------------------------------------------------------------------
  // FIFO: storage is reset so that the head reads as zero out of reset.
  // Pointers are AW bits wide and wrap naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= left;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign m_valid  = !w_empty;
  assign m_data   = r_mem[r_rd_ptr].data;
  assign m_opcd   = r_mem[r_rd_ptr].opcd;
  assign fill     = r_fill;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pe_edge_drain.sv
// -----------------------------------------------------------------------------
// tb_pe_edge_drain: self-checking bench for pe_edge_drain. A queue-based model
// of the capture/drain behaviour is compared against the DUT on every falling
// edge. Directed scenarios add literal expectations, and a randomized phase
// follows them.
// -----------------------------------------------------------------------------
module tb_pe_edge_drain;
  import pe_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  dbus_t                   left;
  logic                    start;
  logic [CW-1:0]           count;
  logic                    busy;
  logic                    done;
  logic                    m_valid;
  logic                    m_ready;
  logic [PE_DW-1:0]        m_data;
  opcd_t                   m_opcd;
  logic [$clog2(DEPTH):0]  fill;
  logic                    overflow;
`ifdef PE_DRAIN_OVF_CNT_EN
  logic [15:0]             ovf_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pe_edge_drain #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .left     (left),
    .start    (start),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_opcd   (m_opcd),
    .fill     (fill),
`ifdef PE_DRAIN_OVF_CNT_EN
    .ovf_cnt  (ovf_cnt),
`endif
    .overflow (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is a queue, and the capture is "words still
  // wanted". A busy block with nothing left to capture is draining.
  // ---------------------------------------------------------------------------
  logic [18:0] mq[$];
  int          cap_left;
  bit          mbusy;
  bit          mdone;
  bit          movf;
  int          movfc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cap_left = 0;
      mbusy    = 1'b0;
      mdone    = 1'b0;
      movf     = 1'b0;
      movfc    = 0;
    end else begin
      int sz0;
      bit pop_now;
      sz0     = mq.size();
      pop_now = (sz0 != 0) && m_ready;
      mdone   = 1'b0;
      if (pop_now) void'(mq.pop_front());
      if (!mbusy) begin
        if (start) begin
          mbusy    = 1'b1;
          cap_left = int'(count);
          movfc    = 0;
          if (count != 0) movf = 1'b0;
        end
      end else if (cap_left != 0) begin
        if (left.opcd != OPCD_PASS) begin
          cap_left--;
          if (mq.size() < int'(DEPTH)) begin
            mq.push_back({left.opcd, left.data});
          end else begin
            movf = 1'b1;
            if (movfc < 65535) movfc++;
          end
        end
      end else if (sz0 == 0) begin
        mbusy = 1'b0;
        mdone = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [18:0] h;
      chk("busy", 32'(busy), 32'(mbusy));
      chk("done", 32'(done), 32'(mdone));
      chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      chk("fill", 32'(fill), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(movf));
`ifdef PE_DRAIN_OVF_CNT_EN
      chk("ovf_cnt", 32'(ovf_cnt), 32'(movfc));
`endif
      if (mq.size() != 0) begin
        h = mq[0];
        chk("m_data", 32'(m_data), 32'(h[15:0]));
        chk("m_opcd", 32'(m_opcd), 32'(h[18:16]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge, and
  // literal checks are made at that point.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input opcd_t o, input logic [15:0] d);
    left.opcd = o;
    left.data = d;
  endtask

  task automatic wait_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    count   = '0;
    left    = '0;
    m_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_opcd", 32'(m_opcd), 32'd0);
`ifdef PE_DRAIN_OVF_CNT_EN
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic capture: 5, 6, 7 with PASS cycles between them.
    m_ready = 1'b1;
    start = 1'b1; count = 16'd3; drive(OPCD_PASS, 16'd0);
    cyc(); chk("basic_busy", 32'(busy), 32'd1);
    start = 1'b0; drive(OPCD_MAC, 16'd5);
    cyc(); chk("basic_v5", 32'(m_valid), 32'd1); chk("basic_d5", 32'(m_data), 32'd5);
    drive(OPCD_PASS, 16'd99);
    cyc(); chk("basic_pop5", 32'(m_valid), 32'd0);
    drive(OPCD_MAC, 16'd6);
    cyc(); chk("basic_d6", 32'(m_data), 32'd6);
    drive(OPCD_PASS, 16'd98); cyc(); cyc();
    drive(OPCD_ADD, 16'd7);
    cyc(); chk("basic_d7", 32'(m_data), 32'd7); chk("basic_busy7", 32'(busy), 32'd1);
    drive(OPCD_PASS, 16'd0);
    cyc(); chk("basic_nodone", 32'(done), 32'd0); chk("basic_fill0", 32'(fill), 32'd0);
    cyc(); chk("basic_done", 32'(done), 32'd1); chk("basic_idle", 32'(busy), 32'd0);
    chk("basic_ovf", 32'(overflow), 32'd0);
    cyc(); chk("basic_done_pulse", 32'(done), 32'd0);

    // Overflow: 10 back-to-back words, no reads.
    m_ready = 1'b0;
    start = 1'b1; count = 16'd10;
    cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(OPCD_ADD, 16'(100 + i));
      cyc();
    end
    chk("ovf_fill", 32'(fill), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
`ifdef PE_DRAIN_OVF_CNT_EN
    chk("ovf_cnt2", 32'(ovf_cnt), 32'd2);
`endif
    drive(OPCD_PASS, 16'd0);
    cyc(); chk("ovf_stay_drain", 32'(busy), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_head", 32'(m_data), 32'(100 + i));
      chk("ovf_busy_pop", 32'(busy), 32'd1);
      cyc();
    end
    chk("ovf_empty", 32'(fill), 32'd0);
    cyc(); chk("ovf_done", 32'(done), 32'd1);

    // Full FIFO with simultaneous push and pop.
    m_ready = 1'b0;
    start = 1'b1; count = 16'd12;
    cyc(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(OPCD_MUL, 16'(200 + i));
      cyc();
    end
    chk("full_fill", 32'(fill), 32'd8);
    chk("full_ovf_cleared", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(OPCD_MUL, 16'(208 + i));
      cyc();
      chk("full_fill_hold", 32'(fill), 32'd8);
      chk("full_no_ovf", 32'(overflow), 32'd0);
    end
    chk("full_head", 32'(m_data), 32'd204);
    drive(OPCD_PASS, 16'd0);
    wait_done(20);

    // count = 0: done one cycle after the accepted start.
    start = 1'b1; count = 16'd0;
    cyc(); chk("zero_busy", 32'(busy), 32'd1);
    start = 1'b0;
    cyc(); chk("zero_done", 32'(done), 32'd1); chk("zero_empty", 32'(m_valid), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);
    cyc();

    // start while ARMED is ignored: exactly 3 words are kept.
    m_ready = 1'b0;
    start = 1'b1; count = 16'd3;
    cyc(); count = 16'd7;
    for (int i = 0; i < 5; i++) begin
      drive(OPCD_LOAD, 16'(300 + i));
      cyc();
    end
    chk("rearm_fill", 32'(fill), 32'd3);
    chk("rearm_busy", 32'(busy), 32'd1);
    chk("rearm_head", 32'(m_data), 32'd300);
    start = 1'b0; drive(OPCD_PASS, 16'd0); m_ready = 1'b1;
    wait_done(20);

    // Asynchronous reset in the middle of a capture.
    m_ready = 1'b0;
    start = 1'b1; count = 16'd5;
    cyc(); start = 1'b0;
    drive(OPCD_OUT, 16'd400); cyc();
    drive(OPCD_OUT, 16'd401); cyc();
    chk("mid_fill_pre", 32'(fill), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_fill", 32'(fill), 32'd0);
    chk("mid_overflow", 32'(overflow), 32'd0);
    chk("mid_m_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(OPCD_PASS, 16'd0);
    cyc(); chk("post_rst_idle", 32'(busy), 32'd0);
    m_ready = 1'b1;
    start = 1'b1; count = 16'd2;
    cyc(); start = 1'b0;
    drive(OPCD_MAC, 16'd500); cyc(); chk("post_rst_d0", 32'(m_data), 32'd500);
    drive(OPCD_MAC, 16'd501); cyc(); chk("post_rst_d1", 32'(m_data), 32'd501);
    drive(OPCD_PASS, 16'd0);
    wait_done(10);

    // Randomized traffic, with the host read rate varied per block.
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned rdy_pct;
      rdy_pct = (blk % 4 == 0) ? 15 : ((blk % 4 == 1) ? 50 : ((blk % 4 == 2) ? 85 : 100));
      for (int i = 0; i < 400; i++) begin
        start   = ($urandom_range(0, 5) == 0);
        count   = 16'($urandom_range(0, 12));
        m_ready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 9) < 4) drive(OPCD_PASS, 16'($urandom));
        else drive(opcd_t'($urandom_range(1, 5)), 16'($urandom));
        cyc();
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
    drive(OPCD_PASS, 16'd0);
    repeat (40) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pe_edge_drain.md
# pe_edge_drain

Receiving end of the systolic PE array's right-edge `dbus_t` stream. Sits on the right output of the last PE in one row and captures a host-requested number of computed words (any opcode other than `OPCD_PASS`). The array never stalls, so captured words are buffered in a FIFO and offered to the host over a valid/ready port, with overflow detection.

## Interface
- `DEPTH`, 8: FIFO entries; a power of two, 2..64.
- `CW`, 16: capture-count width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `left` in `dbus_t`: stream from the row's last PE `right` output; fields `opcd` (`opcd_t`) and `data` (DW = `$bits(dbus_t.data)`).
- `start` in 1: arm a capture; honoured only in IDLE.
- `count` in CW: number of words to capture; sampled with `start`.
- `busy` out 1: high in ARMED or DRAIN.
- `done` out 1: one-cycle pulse on the DRAIN→IDLE transition.
- `m_valid` out 1: FIFO head valid (FIFO not empty).
- `m_ready` in 1: host accepts the head.
- `m_data` out DW: FIFO head data.
- `m_opcd` out `opcd_t`: FIFO head opcode.
- `fill` out clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; at least one qualifying word was dropped.
- `ovf_cnt` out 16: dropped-word count; present only with `PE_DRAIN_OVF_CNT_EN`.

## Operation
- States: IDLE, ARMED, DRAIN. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `fill`=0, `overflow`=0, `ovf_cnt`=0. FIFO pointers are 0 and `remaining` is 0. `m_data` and `m_opcd` are 0.
- IDLE:
  - `start`=1 with `count`>0: load `remaining`=`count`, clear `overflow` (and `ovf_cnt`), go to ARMED.
  - `start`=1 with `count`=0: go to DRAIN.
- ARMED: a cycle qualifies when `left.opcd != OPCD_PASS`.
  - Each qualifying cycle decrements `remaining`.
  - `{opcd,data}` is pushed if the FIFO is not full. Otherwise the word is dropped, `overflow` is set to 1, and `ovf_cnt` saturates at 0xFFFF.
  - When the decrement reaches 0, go to DRAIN. `OPCD_PASS` cycles are ignored entirely.
- DRAIN: no captures. When `fill`=0, go to IDLE and pulse `done`.
- `start` is ignored when `busy`=1.
- Pop happens when `m_valid && m_ready`. FIFO pop is allowed in every state, including IDLE; leftover words stay until popped.
- Push and pop in the same cycle:
  - When not empty: `fill` is unchanged.
  - When full: the pop frees the slot, so the push is accepted and nothing is dropped.
  - When empty: no pop occurs; the push lands normally.
- Pointers wrap modulo DEPTH; full is `fill`==DEPTH.
- Asserting `rst_n` low mid-capture asynchronously returns every output to its reset value. FIFO contents are discarded.

## Timing
- `left` is sampled on edge k. A pushed word drives `m_valid`=1 and `m_data` after edge k, so latency is 1 cycle when the FIFO was empty.
- ARMED→DRAIN happens on the edge that captures the last word. DRAIN→IDLE happens on the first edge at which `fill`=0; `done` is high for the following cycle only.
- A `start` accepted on edge k gives `busy`=1 after edge k. The first qualifying word can be sampled on edge k+1.
- `m_data` and `m_opcd` are stable while `m_valid`=1 and `m_ready`=0.
- Throughput is one push and one pop per cycle.

## Configuration
- `PE_DRAIN_OVF_CNT_EN` defined:
  - `ovf_cnt` port and its 16-bit saturating counter are present.
  - The counter is cleared by reset and by an accepted `start`.
- `PE_DRAIN_OVF_CNT_EN` not defined:
  - no `ovf_cnt` port or counter.
  - Only the sticky `overflow` flag reports drops.
  - All other behaviour is identical.

## Test plan
- Basic capture: `start`, `count`=3, `m_ready`=1; `left` carries non-PASS data 5, 6, 7 with PASS cycles interleaved -> `m_data` shows 5, 6, 7 in order, each 1 cycle after sampling. `done` pulses once after the third pop cycle, and `overflow`=0.
- Overflow (DEPTH=8): `count`=10 on back-to-back non-PASS cycles with `m_ready`=0 -> `fill`=8, `overflow`=1, `ovf_cnt`=2, the FIFO holds the first 8 words, and the state stays DRAIN until 8 pops complete.
- Full plus simultaneous push/pop: fill 8, then hold `m_ready`=1 while 4 more non-PASS words arrive -> no drops, `overflow`=0, `fill` stays 8 until the input stops.
- Edge cases: `count`=0 -> `done` pulses 1 cycle later with the FIFO empty. `start` during ARMED is ignored and `remaining` is unchanged.
- Reset mid-capture: drop `rst_n` asynchronously after 2 of 5 words -> `m_valid`, `busy`, `fill`, and `overflow` go to 0 immediately. After release the block sits in IDLE, and a new `start` captures correctly.
